// File: rtl/axis_gpio_event_timestamper.sv
// Masked change detector that timestamps GPIO samples and queues {timestamp, sample} events in a FWFT FIFO.
// Optional AXIS_GPIO_EVENT_DROP_CNT_EN adds a saturating sts_drop_count output.
module axis_gpio_event_timestamper #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned TS_WIDTH         = 32,
    parameter int unsigned FIFO_ADDR_WIDTH  = 4
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 cfg_enable,
    input  logic [AXIS_TDATA_WIDTH-1:0]          cfg_mask,
    input  logic [AXIS_TDATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    output logic [TS_WIDTH+AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [FIFO_ADDR_WIDTH:0]             sts_count,
    output logic                                 sts_overflow
`ifdef AXIS_GPIO_EVENT_DROP_CNT_EN
    ,
    output logic [31:0]                          sts_drop_count
`endif
);

    localparam int unsigned EW    = TS_WIDTH + AXIS_TDATA_WIDTH;
    localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

    logic [TS_WIDTH-1:0]         ts_q, ts_d;
    logic [AXIS_TDATA_WIDTH-1:0] prev_q, prev_d;
    logic                        prev_valid_q, prev_valid_d;
    logic                        evt_valid_q, evt_valid_d;
    logic [EW-1:0]               evt_data_q, evt_data_d;
    logic [EW-1:0]               mem_q [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]    count_q, count_d;
    logic                        ovf_q, ovf_d;
    logic                        pop, full, push, mem_we;
`ifdef AXIS_GPIO_EVENT_DROP_CNT_EN
    logic [31:0]                 drop_q, drop_d;
`endif

    assign full = (count_q == FULL);
    assign pop  = (count_q != '0) && m_axis_tready;
    // A full FIFO still takes the write when the head is leaving in the same cycle.
    assign push = evt_valid_q && (!full || pop);

    always_comb begin
        ts_d         = ts_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        evt_valid_d  = 1'b0;
        evt_data_d   = evt_data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        mem_we       = 1'b0;
`ifdef AXIS_GPIO_EVENT_DROP_CNT_EN
        drop_d       = drop_q;
`endif
        if (!cfg_enable) begin
            ts_d         = '0;
            prev_valid_d = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            ovf_d        = 1'b0;
`ifdef AXIS_GPIO_EVENT_DROP_CNT_EN
            drop_d       = '0;
`endif
        end else begin
            ts_d = ts_q + TS_WIDTH'(1);
            if (s_axis_tvalid) begin
                evt_valid_d  = prev_valid_q && (((s_axis_tdata ^ prev_q) & cfg_mask) != '0);
                evt_data_d   = {ts_q, s_axis_tdata};
                prev_d       = s_axis_tdata;
                prev_valid_d = 1'b1;
            end
            mem_we = push;
            if (push) begin
                wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
            end
            count_d = count_q + (FIFO_ADDR_WIDTH + 1)'(push) - (FIFO_ADDR_WIDTH + 1)'(pop);
            if (evt_valid_q && !push) begin
                ovf_d = 1'b1;
`ifdef AXIS_GPIO_EVENT_DROP_CNT_EN
                if (drop_q != '1) begin
                    drop_d = drop_q + 32'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ts_q         <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_data_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
`ifdef AXIS_GPIO_EVENT_DROP_CNT_EN
            drop_q       <= '0;
`endif
        end else begin
            ts_q         <= ts_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            evt_valid_q  <= evt_valid_d;
            evt_data_q   <= evt_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
`ifdef AXIS_GPIO_EVENT_DROP_CNT_EN
            drop_q       <= drop_d;
`endif
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we && aresetn) begin
            mem_q[wr_ptr_q] <= evt_data_q;
        end
    end

    assign s_axis_tready = 1'b1;
    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign m_axis_tvalid = (count_q != '0);
    assign sts_count     = count_q;
    assign sts_overflow  = ovf_q;
`ifdef AXIS_GPIO_EVENT_DROP_CNT_EN
    assign sts_drop_count = drop_q;
`endif

endmodule
